sram_rw_port_ctrl: RTL and testbench

SRAM_RW_PORT_CTRL -- requirements
Module: sram_rw_port_ctrl

---
 rtl/sram_ctrl_pkg.sv | 16 +
 rtl/sram_rw_port_ctrl.sv | 126 ++++++++++++
 tb/tb_sram_rw_port_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizing for the SRAM read/write port controller.
// Holds the controller state enum and the default geometry constants.
// Imported by sram_rw_port_ctrl; no logic lives here.
package sram_ctrl_pkg;

    // Controller phases: zero-sweep after reset, then normal request service
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_DEPTH  = 256;
    localparam int DEF_WIDTH  = 2;
    localparam int DEF_MASK_W = 1;

endpackage

// File: rtl/sram_rw_port_ctrl.sv
// Purpose: single-port SRAM arbiter; zero-sweeps the array after reset, then serves writes (priority) and reads.
// Latency: write/read issued to SRAM same cycle; read response 1 cycle after acceptance.
// Backpressure: both readies low during sweep; r_ready drops whenever w_valid is high. Option: SRAM_CTRL_HOLD_READ_EN.
module sram_rw_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int MASK_W = DEF_MASK_W,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [WIDTH-1:0]  w_data,
    input  logic [MASK_W-1:0] w_mask,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_resp_valid,
    output logic [WIDTH-1:0]  r_resp_data,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [WIDTH-1:0]  sram_wdata,
    input  logic [WIDTH-1:0]  sram_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rvld_q, rvld_d;
    logic              wr_fire, rd_fire;

    // Handshakes: writes always win while running, reads only when no write is offered
    always_comb begin
        w_ready   = (state_q == RUN);
        r_ready   = (state_q == RUN) && !w_valid;
        init_done = (state_q == RUN);
        wr_fire   = w_valid && w_ready;
        rd_fire   = r_valid && r_ready;
    end

    // Sweep sequencing: walk every address once, stop at the top without wrapping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rvld_d  = rd_fire;
        if (state_q == INIT) begin
            if (cnt_q == LAST_ADDR) begin
                state_d = RUN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State, sweep counter and response-valid flops; reset aborts any in-flight read
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            rvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rvld_q  <= rvld_d;
        end
    end

    // SRAM port mux: sweep write, accepted write, accepted read, else fully quiet
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        if (state_q == INIT) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = cnt_q;
            sram_wmask = '1;
        end else if (wr_fire) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = w_addr;
            sram_wmask = w_mask;
            sram_wdata = w_data;
        end else if (rd_fire) begin
            sram_en    = 1'b1;
            sram_addr  = r_addr;
        end
    end

    assign r_resp_valid = rvld_q;

`ifdef SRAM_CTRL_HOLD_READ_EN
    logic [WIDTH-1:0] hold_q, hold_d;

    // Latch the SRAM output on every response so it stays visible until the next one
    always_comb begin
        hold_d      = rvld_q ? sram_rdata : hold_q;
        r_resp_data = rvld_q ? sram_rdata : hold_q;
    end

    // Held read data register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    // Read data is only meaningful in the response cycle; zero otherwise
    always_comb begin
        r_resp_data = rvld_q ? sram_rdata : '0;
    end
`endif

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Directed bench for sram_rw_port_ctrl with a behavioural 1-cycle SRAM.
// Read responses are checked by a scoreboard monitor; port/handshake values checked inline.
// Honours SRAM_CTRL_HOLD_READ_EN for the idle-cycle read data expectation.
module tb_sram_rw_port_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       w_valid, w_ready;
    logic [7:0] w_addr;
    logic [1:0] w_data;
    logic [0:0] w_mask;
    logic       r_valid, r_ready;
    logic [7:0] r_addr;
    logic       r_resp_valid;
    logic [1:0] r_resp_data;
    logic       init_done;
    logic       sram_en, sram_wmode;
    logic [7:0] sram_addr;
    logic [0:0] sram_wmask;
    logic [1:0] sram_wdata;
    logic [1:0] sram_rdata;

`ifdef SRAM_CTRL_HOLD_READ_EN
    localparam logic [1:0] HOLD_EXP = 2'b11;
`else
    localparam logic [1:0] HOLD_EXP = 2'b00;
`endif

    always #5 clock = ~clock;

    sram_rw_port_ctrl #(.DEPTH(256), .WIDTH(2), .MASK_W(1), .ADDR_W(8)) dut (
        .clock(clock), .reset(reset),
        .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
        .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
        .r_resp_valid(r_resp_valid), .r_resp_data(r_resp_data), .init_done(init_done),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Behavioural SRAM: starts with non-zero contents so the sweep is observable
    logic [1:0] mem [0:255];
    logic [1:0] rd_q = 2'b00;
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 2'b01;
    end
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                if (sram_wmask[0]) mem[sram_addr] <= sram_wdata;
            end else begin
                rd_q <= mem[sram_addr];
            end
        end
    end
    assign sram_rdata = rd_q;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int         c;
        logic [1:0] d;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pk(input logic en, input logic wm, input logic [7:0] a,
                                       input logic m, input logic [1:0] d);
        return {19'b0, en, wm, a, m, d};
    endfunction

    logic [31:0] port_v;
    logic [31:0] hs_v;
    assign port_v = {19'b0, sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata};
    assign hs_v   = {29'b0, w_ready, r_ready, init_done};

    // Monitor: every response must match the oldest expectation in data and cycle
    always @(negedge clock) begin
        if (r_resp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got data 0x%0h with no read outstanding (cycle %0d)",
                         r_resp_data, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("resp_cycle", 32'(cyc), 32'(e.c));
                chk("resp_data", 32'(r_resp_data), 32'(e.d));
            end
        end
    end

    task automatic chk_reset_state(input string nm);
        chk({nm, "_hs"}, hs_v, 32'b0);
        chk({nm, "_rvld"}, 32'(r_resp_valid), 32'b0);
        chk({nm, "_rdata"}, 32'(r_resp_data), 32'b0);
    endtask

    // Check n sweep cycles starting at address 0; optionally drop request valids at drop_at
    task automatic sweep(input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk("sweep_port", port_v, pk(1'b1, 1'b1, 8'(i), 1'b1, 2'b00));
            chk("sweep_hs", hs_v, 32'b0);
            if (i == drop_at) begin
                w_valid = 1'b0;
                r_valid = 1'b0;
            end
        end
    endtask

    task automatic idle();
        @(posedge clock); #1;
        w_valid = 1'b0;
        r_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [1:0] d, input logic m);
        @(posedge clock); #1;
        r_valid = 1'b0;
        w_valid = 1'b1;
        w_addr  = a;
        w_data  = d;
        w_mask  = m;
        @(negedge clock);
        chk("wr_port", port_v, pk(1'b1, 1'b1, a, m, d));
        chk("wr_hs", hs_v, 32'b101);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [1:0] d);
        exp_t e;
        @(posedge clock); #1;
        w_valid = 1'b0;
        r_valid = 1'b1;
        r_addr  = a;
        e.c = cyc + 1;
        e.d = d;
        sbq.push_back(e);
        @(negedge clock);
        chk("rd_port", {port_v[31:3], 3'b0}, {pk(1'b1, 1'b0, a, 1'b0, 2'b00)} & ~32'h7);
        chk("rd_hs", hs_v, 32'b111);
    endtask

    initial begin
        w_valid = 1'b0; w_addr = 8'h00; w_data = 2'b00; w_mask = 1'b0;
        r_valid = 1'b0; r_addr = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_reset_state("por");

        // Requests offered during the sweep must be ignored
        w_valid = 1'b1; w_addr = 8'h10; w_data = 2'b11; w_mask = 1'b1;
        r_valid = 1'b1; r_addr = 8'h44;
        @(posedge clock); #1;
        reset = 1'b0;
        sweep(256, 199);
        @(negedge clock);
        chk("run_idle_port", port_v, 32'b0);
        chk("run_idle_hs", hs_v, 32'b111);

        // Write then immediate read of the same address
        do_write(8'h10, 2'b11, 1'b1);
        do_read(8'h10, 2'b11);
        idle();
        repeat (2) begin
            idle();
            chk("idle_rvld", 32'(r_resp_valid), 32'b0);
            chk("idle_rdata", 32'(r_resp_data), 32'(HOLD_EXP));
            chk("idle_port", port_v, 32'b0);
        end

        // Simultaneous write and read: write wins, read goes next cycle
        @(posedge clock); #1;
        w_valid = 1'b1; w_addr = 8'h20; w_data = 2'b10; w_mask = 1'b1;
        r_valid = 1'b1; r_addr = 8'h10;
        @(negedge clock);
        chk("both_port", port_v, pk(1'b1, 1'b1, 8'h20, 1'b1, 2'b10));
        chk("both_hs", hs_v, 32'b101);
        do_read(8'h10, 2'b11);

        // Zero-mask write is accepted but leaves memory untouched
        do_write(8'h01, 2'b11, 1'b0);
        do_write(8'h02, 2'b01, 1'b1);
        do_write(8'h03, 2'b10, 1'b1);

        // Back-to-back reads
        do_read(8'h01, 2'b00);
        do_read(8'h02, 2'b01);
        do_read(8'h03, 2'b10);
        do_read(8'h20, 2'b10);
        idle();
        idle();

        // Reset while a read is being issued: its response must never appear
        @(posedge clock); #1;
        r_valid = 1'b1; r_addr = 8'h10;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk_reset_state("rst_mid_read");
        r_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset during the sweep at address 100
        sweep(101, -1);
        reset = 1'b1;
        #1;
        chk_reset_state("rst_mid_sweep");
        chk("rst_mid_sweep_addr", 32'(sram_addr), 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        sweep(256, -1);
        @(negedge clock);
        chk("rerun_hs", hs_v, 32'b111);

        // Array is zero again after the restarted sweep
        do_read(8'h10, 2'b00);
        do_read(8'h20, 2'b00);
        idle();
        idle();
        chk("sb_empty", 32'(sbq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
